dmem_access_unit: RTL and testbench

- MEM-stage load/store unit of the MIPS pipeline, sitting between the EX/MEM register and the word-addressed data RAM.
- Converts byte addresses to word indices and performs byte/halfword/word loads with sign or zero extension.
- Performs sub-word stores as a 2-cycle read-modify-write and stalls the pipeline while it does so.
- Checks alignment and range, and registers the result into the MEM/WB outputs.

---
 rtl/dmem_access_unit.sv | 154 +++++++++++++++
 tb/tb_dmem_access_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: word-indexed RAM access, sub-word extraction/extension,
// 2-cycle read-modify-write for byte/half stores, exception checks, MEM/WB registers.
module dmem_access_unit #(
    parameter int DEPTH = 21,
    parameter int IDX_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_data_in,
    output logic        dmem_mem_write,
    output logic        dmem_mem_read,
    input  logic [31:0] dmem_data_out,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic [1:0]  exc_code
);

    // state | meaning
    // IDLE  | accept a new request; loads, word stores and pass-through finish here
    // RMW   | second cycle of a byte/half store: write merged word back
    typedef enum logic {IDLE, RMW} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_RANGE = 2'b10;
    localparam logic [1:0] EXC_ILL   = 2'b11;

    state_t      state;
    logic [31:0] hold;

    logic        is_mem;
    logic        exc_ill;
    logic        exc_align;
    logic        exc_range;
    logic [1:0]  exc;
    logic        go;
    logic        sub_store;
    logic [31:0] merged;
    logic [31:0] load_val;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign is_mem    = mem_read | mem_write;
    assign exc_ill   = is_mem & ((mem_read & mem_write) | (size == 2'b11));
    assign exc_align = is_mem & (((size == SZ_HALF) & addr[0]) |
                                 ((size == SZ_WORD) & (addr[1:0] != 2'b00)));
    assign exc_range = is_mem & ({2'b00, addr[31:2]} >= 32'(DEPTH));

    always_comb begin
        exc = EXC_NONE;
        if (exc_ill)
            exc = EXC_ILL;
        else if (exc_align)
            exc = EXC_ALIGN;
        else if (exc_range)
            exc = EXC_RANGE;
    end

    assign go        = (state == IDLE) & req_valid & (exc == EXC_NONE);
    assign sub_store = mem_write & ~mem_read & (size != SZ_WORD);

    // Strobes and stall are gated by reset so nothing reaches the RAM while it is held.
    assign stall          = reset & go & sub_store;
    assign dmem_mem_read  = reset & go & (mem_read | sub_store);
    assign dmem_mem_write = reset & ((go & mem_write & ~sub_store) | (state == RMW));
    assign dmem_address   = {{(32-IDX_W){1'b0}}, addr[IDX_W+1:2]};
    assign dmem_data_in   = (state == RMW) ? merged : store_data;

    always_comb begin
        merged = hold;
        if (size == SZ_BYTE)
            merged[{addr[1:0], 3'b000} +: 8] = store_data[7:0];
        else
            merged[{addr[1], 4'b0000} +: 16] = store_data[15:0];
    end

    assign byte_v = dmem_data_out[{addr[1:0], 3'b000} +: 8];
    assign half_v = dmem_data_out[{addr[1], 4'b0000} +: 16];

    always_comb begin
        case (size)
            SZ_BYTE: load_val = load_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_HALF: load_val = load_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_val = dmem_data_out;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            hold          <= 32'h0;
            wb_valid      <= 1'b0;
            wb_data       <= 32'h0;
            rd_out        <= 5'h0;
            reg_write_out <= 1'b0;
            exc_code      <= EXC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (!req_valid) begin
                        wb_valid      <= 1'b0;
                        reg_write_out <= 1'b0;
                        exc_code      <= EXC_NONE;
                    end else if (exc != EXC_NONE) begin
                        wb_valid      <= 1'b1;
                        wb_data       <= addr;
                        rd_out        <= rd_in;
                        reg_write_out <= 1'b0;
                        exc_code      <= exc;
                    end else if (sub_store) begin
                        hold          <= dmem_data_out;
                        state         <= RMW;
                        wb_valid      <= 1'b0;
                        reg_write_out <= 1'b0;
                        exc_code      <= EXC_NONE;
                    end else begin
                        wb_valid      <= 1'b1;
                        wb_data       <= mem_read ? load_val : addr;
                        rd_out        <= rd_in;
                        reg_write_out <= reg_write_in & ~mem_write;
                        exc_code      <= EXC_NONE;
                    end
                end
                RMW: begin
                    state         <= IDLE;
                    wb_valid      <= 1'b1;
                    wb_data       <= addr;
                    rd_out        <= rd_in;
                    reg_write_out <= 1'b0;
                    exc_code      <= EXC_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized and directed checks of dmem_access_unit against a word-array reference model.
module tb_dmem_access_unit;

    localparam int DEPTH = 21;
    localparam int IDX_W = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [4:0]  rd_in = 5'h0;
    logic        reg_write_in = 1'b0;
    logic        stall;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic        dmem_mem_write;
    logic        dmem_mem_read;
    logic [31:0] dmem_data_out;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic [1:0]  exc_code;

    logic [31:0] ram [0:31] = '{default: 32'h0};
    logic [31:0] ref_mem [0:DEPTH-1];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_access_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .load_unsigned(load_unsigned), .addr(addr),
        .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in), .stall(stall),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_mem_write(dmem_mem_write), .dmem_mem_read(dmem_mem_read),
        .dmem_data_out(dmem_data_out), .wb_valid(wb_valid), .wb_data(wb_data),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_mem_write) ram[dmem_address[4:0]] <= dmem_data_in;
    end
    assign dmem_data_out = ram[dmem_address[4:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One instruction through the unit; expectations come from the word-array model.
    task automatic do_op(input logic v, input logic r, input logic w, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rdi, input logic rwi);
        int unsigned idx;
        int unsigned sh;
        logic [1:0]  e;
        logic [31:0] old;
        logic [31:0] nv;
        logic [31:0] lv;
        logic [31:0] mask;
        logic        ok;
        logic        sub;
        idx = a[31:2];
        e = 2'd0;
        if (r || w) begin
            if ((r && w) || sz == 2'd3) e = 2'd3;
            else if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) e = 2'd1;
            else if (idx >= DEPTH) e = 2'd2;
        end
        ok  = v && e == 2'd0;
        old = (idx < DEPTH) ? ref_mem[idx] : 32'h0;
        sh  = (sz == 2'd0) ? 8 * a[1:0] : 16 * a[1];
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        if (sz == 2'd2) begin
            lv = old;
            nv = sd;
        end else begin
            lv = (old >> sh) & mask;
            if (!uns) lv = (lv ^ ((mask + 1) >> 1)) - ((mask + 1) >> 1);
            nv = (old & ~(mask << sh)) | ((sd & mask) << sh);
        end
        sub = ok && w && sz != 2'd2;

        @(negedge clk);
        req_valid = v; mem_read = r; mem_write = w; size = sz; load_unsigned = uns;
        addr = a; store_data = sd; rd_in = rdi; reg_write_in = rwi;
        #1;
        check("stall", 32'(stall), 32'(sub));
        check("mem_read", 32'(dmem_mem_read), 32'(ok && (r || sub)));
        check("mem_write", 32'(dmem_mem_write), 32'(ok && w && !sub));
        if (ok && (r || w)) check("address", dmem_address, 32'(idx));
        if (ok && w && !sub) check("data_in", dmem_data_in, sd);
        @(posedge clk);
        #1;
        if (sub) begin
            check("rmw_bubble", 32'(wb_valid), 32'd0);
            check("rmw_stall", 32'(stall), 32'd0);
            check("rmw_write", 32'(dmem_mem_write), 32'd1);
            check("rmw_read", 32'(dmem_mem_read), 32'd0);
            check("rmw_data", dmem_data_in, nv);
            @(posedge clk);
            #1;
        end
        if (ok && w) begin
            ref_mem[idx] = nv;
            check("ram_word", ram[idx], nv);
        end
        check("wb_valid", 32'(wb_valid), 32'(v));
        check("reg_write_out", 32'(reg_write_out), 32'(ok && !w && rwi));
        check("exc_code", 32'(exc_code), v ? 32'(e) : 32'd0);
        if (v) begin
            check("wb_data", wb_data, (ok && r) ? lv : a);
            check("rd_out", 32'(rd_out), 32'(rdi));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        check("rst_reg_write", 32'(reg_write_out), 32'd0);
        check("rst_exc", 32'(exc_code), 32'd0);
        check("rst_mem_write", 32'(dmem_mem_write), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(1, 0, 1, 2'd2, 0, 32'h0C, 32'hDEADBEEF, 5'd0, 1'b1);
        do_op(1, 1, 0, 2'd2, 0, 32'h0C, 32'h0, 5'd8, 1'b1);
        do_op(1, 0, 1, 2'd0, 0, 32'h0D, 32'h55, 5'd0, 1'b0);
        check("sb_result", ram[3], 32'hDEAD55EF);
        do_op(1, 1, 0, 2'd0, 1, 32'h0D, 32'h0, 5'd9, 1'b1);
        check("lbu_value", wb_data, 32'h00000055);
        do_op(1, 1, 0, 2'd0, 0, 32'h0F, 32'h0, 5'd10, 1'b1);
        check("lb_value", wb_data, 32'hFFFFFFDE);
        do_op(1, 0, 1, 2'd1, 0, 32'h12, 32'h8001, 5'd0, 1'b0);
        check("sh_result", ram[4], 32'h80010000);
        do_op(1, 1, 0, 2'd1, 0, 32'h12, 32'h0, 5'd11, 1'b1);
        check("lh_value", wb_data, 32'hFFFF8001);
        do_op(1, 1, 0, 2'd1, 1, 32'h12, 32'h0, 5'd12, 1'b1);
        check("lhu_value", wb_data, 32'h00008001);
        do_op(1, 1, 0, 2'd2, 0, 32'h0E, 32'h0, 5'd3, 1'b1);
        do_op(1, 0, 1, 2'd2, 0, 32'h54, 32'h1, 5'd3, 1'b1);
        do_op(1, 1, 1, 2'd2, 0, 32'h10, 32'h1, 5'd3, 1'b1);
        do_op(1, 0, 0, 2'd2, 0, 32'h1234, 32'h0, 5'd7, 1'b1);
        do_op(1, 0, 1, 2'd0, 0, 32'h50, 32'h11, 5'd0, 1'b1);
        do_op(1, 0, 1, 2'd0, 0, 32'h53, 32'h22, 5'd0, 1'b1);
        do_op(1, 1, 0, 2'd2, 0, 32'h50, 32'h0, 5'd1, 1'b1);
        do_op(0, 1, 0, 2'd2, 0, 32'h50, 32'h0, 5'd1, 1'b1);

        // reset asserted during the write-back cycle of a byte store
        @(negedge clk);
        req_valid = 1; mem_read = 0; mem_write = 1; size = 2'd0; addr = 32'h08;
        store_data = 32'hA5; reg_write_in = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rstrmw_write", 32'(dmem_mem_write), 32'd0);
        check("rstrmw_stall", 32'(stall), 32'd0);
        check("rstrmw_wb_valid", 32'(wb_valid), 32'd0);
        check("rstrmw_wb_data", wb_data, 32'd0);
        check("rstrmw_exc", 32'(exc_code), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstrmw_ram", ram[2], ref_mem[2]);
        do_op(1, 1, 0, 2'd2, 0, 32'h08, 32'h0, 5'd4, 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int unsigned kind;
            kind = $urandom_range(0, 9);
            sz   = 2'($urandom_range(0, 3));
            a    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 95));
            if ($urandom_range(0, 1) == 1 && sz != 2'd0) a = a & ~((sz == 2'd1) ? 32'h1 : 32'h3);
            do_op($urandom_range(0, 7) != 0, kind < 4 || kind == 9, (kind >= 4 && kind < 8) || kind == 9,
                  sz, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom));
        end

        @(negedge clk);
        req_valid = 0;
        for (int i = 0; i < DEPTH; i++) check("final_ram", ram[i], ref_mem[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
